// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter in front of a single-port synchronous memory.
//
// Requesters present a transfer with reqN_valid and hold it until reqN_ready. An idle
// arbiter grants round-robin. A transfer with reqN_lock=1 keeps the grant with N for
// the following transfers. A lock is broken after LOCK_MAX consecutive locked transfers,
// which raises lock_err for one cycle. Accepted transfers become a registered memory
// command on the next cycle. Read data returns on the shared rdata bus two cycles
// after acceptance, flagged by the owner's reqN_rvalid.
//
// Ports
//   clk, rst                       clock, asynchronous active-low reset
//   reqN_valid/we/lock/addr/wdata  requester N transfer (N = 0, 1)
//   reqN_ready                     transfer accepted this cycle (combinational)
//   reqN_rvalid                    read data on rdata belongs to requester N
//   rdata                          shared read data (same as mem_rdata)
//   mem_en/mem_wr_en/mem_addr/mem_wdata  registered memory command
//   mem_rdata                      memory read data, one cycle after a read command
//   lock_err                       one-cycle pulse when a lock is forcibly broken
module mem_arbiter #(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned ADDR_SIZE = 8,
  parameter int unsigned LOCK_MAX  = 16
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 req0_valid,
  input  logic                 req0_we,
  input  logic                 req0_lock,
  input  logic [ADDR_SIZE-1:0] req0_addr,
  input  logic [WORD_SIZE-1:0] req0_wdata,
  output logic                 req0_ready,
  output logic                 req0_rvalid,

  input  logic                 req1_valid,
  input  logic                 req1_we,
  input  logic                 req1_lock,
  input  logic [ADDR_SIZE-1:0] req1_addr,
  input  logic [WORD_SIZE-1:0] req1_wdata,
  output logic                 req1_ready,
  output logic                 req1_rvalid,

  output logic [WORD_SIZE-1:0] rdata,

  output logic                 mem_en,
  output logic                 mem_wr_en,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,

  output logic                 lock_err
);

  localparam int unsigned CntW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX + 1) : 1;
  localparam logic [CntW-1:0] LockMaxC = CntW'(LOCK_MAX);

  typedef enum logic [1:0] {
    StIdle,
    StOwn0,
    StOwn1
  } state_e;

  // Arbiter state
  state_e          state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic [CntW-1:0] lock_cnt_q, lock_cnt_d;
  logic            lock_err_q, lock_err_d;

  // Memory command stage
  logic                 mem_en_q, mem_en_d;
  logic                 mem_wr_en_q, mem_wr_en_d;
  logic [ADDR_SIZE-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_SIZE-1:0] mem_wdata_q, mem_wdata_d;

  // Read return tracking: stage 1 is the command cycle, stage 2 the data cycle
  logic rd_pend_q, rd_pend_d;
  logic rd_tag_q, rd_tag_d;
  logic rvalid0_q, rvalid0_d;
  logic rvalid1_q, rvalid1_d;

  // Grant and selected transfer
  logic                 gnt0, gnt1;
  logic                 xfer;
  logic                 xfer_sel;
  logic                 xfer_we;
  logic                 xfer_lock;
  logic [ADDR_SIZE-1:0] xfer_addr;
  logic [WORD_SIZE-1:0] xfer_wdata;
  logic [CntW-1:0]      lock_cnt_inc;

  // Grant decode. On a tie in idle, the requester that did not transfer last wins.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req0_valid && req1_valid) begin
          gnt0 = last_grant_q;
          gnt1 = ~last_grant_q;
        end else begin
          gnt0 = req0_valid;
          gnt1 = req1_valid;
        end
      end
      StOwn0: gnt0 = req0_valid;
      StOwn1: gnt1 = req1_valid;
      default: begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
      end
    endcase
  end

  // Gated by reset so nothing reports acceptance while the state is held in reset.
  assign req0_ready = gnt0 & rst;
  assign req1_ready = gnt1 & rst;

  assign xfer       = req0_ready | req1_ready;
  assign xfer_sel   = req1_ready;
  assign xfer_we    = xfer_sel ? req1_we    : req0_we;
  assign xfer_lock  = xfer_sel ? req1_lock  : req0_lock;
  assign xfer_addr  = xfer_sel ? req1_addr  : req0_addr;
  assign xfer_wdata = xfer_sel ? req1_wdata : req0_wdata;

  assign lock_cnt_inc = lock_cnt_q + CntW'(1);

  // Arbiter next state
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    lock_cnt_d   = lock_cnt_q;
    lock_err_d   = 1'b0;
    if (xfer) begin
      last_grant_d = xfer_sel;
      if (xfer_lock) begin
        if (lock_cnt_inc == LockMaxC) begin
          // Lock limit reached: force release. last_grant already points at the
          // owner, so the other requester wins the next tie.
          state_d    = StIdle;
          lock_cnt_d = '0;
          lock_err_d = 1'b1;
        end else begin
          state_d    = xfer_sel ? StOwn1 : StOwn0;
          lock_cnt_d = lock_cnt_inc;
        end
      end else begin
        state_d    = StIdle;
        lock_cnt_d = '0;
      end
    end
  end

  // Memory command and read-return next state
  always_comb begin
    mem_en_d    = xfer;
    mem_wr_en_d = xfer & xfer_we;
    // Address and data hold their last value between commands.
    mem_addr_d  = xfer ? xfer_addr  : mem_addr_q;
    mem_wdata_d = xfer ? xfer_wdata : mem_wdata_q;
    rd_pend_d   = xfer & ~xfer_we;
    rd_tag_d    = xfer ? xfer_sel : rd_tag_q;
    rvalid0_d   = rd_pend_q & ~rd_tag_q;
    rvalid1_d   = rd_pend_q & rd_tag_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      lock_cnt_q   <= '0;
      lock_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      lock_cnt_q   <= lock_cnt_d;
      lock_err_q   <= lock_err_d;
    end
  end

  // Reset clears in-flight commands and pending read returns.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_en_q    <= 1'b0;
      mem_wr_en_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_pend_q   <= 1'b0;
      rd_tag_q    <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
    end else begin
      mem_en_q    <= mem_en_d;
      mem_wr_en_q <= mem_wr_en_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rd_pend_q   <= rd_pend_d;
      rd_tag_q    <= rd_tag_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
    end
  end

  assign mem_en      = mem_en_q;
  assign mem_wr_en   = mem_wr_en_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign req0_rvalid = rvalid0_q;
  assign req1_rvalid = rvalid1_q;
  assign rdata       = mem_rdata;
  assign lock_err    = lock_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a behavioural memory.
module tb_mem_arbiter;

  localparam int WS = 16;
  localparam int AS = 8;
  localparam int LM = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_valid = 1'b0, req0_we = 1'b0, req0_lock = 1'b0;
  logic [AS-1:0] req0_addr = '0;
  logic [WS-1:0] req0_wdata = '0;
  logic          req1_valid = 1'b0, req1_we = 1'b0, req1_lock = 1'b0;
  logic [AS-1:0] req1_addr = '0;
  logic [WS-1:0] req1_wdata = '0;
  logic          req0_ready, req0_rvalid, req1_ready, req1_rvalid;
  logic [WS-1:0] rdata;
  logic          mem_en, mem_wr_en;
  logic [AS-1:0] mem_addr;
  logic [WS-1:0] mem_wdata;
  logic [WS-1:0] mem_rdata = '0;
  logic          lock_err;

  always #5 clk = ~clk;

  mem_arbiter #(
    .WORD_SIZE(WS),
    .ADDR_SIZE(AS),
    .LOCK_MAX (LM)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_we    (req0_we),
    .req0_lock  (req0_lock),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .req0_ready (req0_ready),
    .req0_rvalid(req0_rvalid),
    .req1_valid (req1_valid),
    .req1_we    (req1_we),
    .req1_lock  (req1_lock),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .req1_ready (req1_ready),
    .req1_rvalid(req1_rvalid),
    .rdata      (rdata),
    .mem_en     (mem_en),
    .mem_wr_en  (mem_wr_en),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .lock_err   (lock_err)
  );

  function automatic logic [WS-1:0] init_pat(input logic [AS-1:0] a);
    return {a, ~a};
  endfunction

  // Behavioural memory: one-cycle read latency, unwritten words read as init_pat.
  logic [WS-1:0] mem_arr [256];
  bit            written [256];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wr_en) begin
        mem_arr[mem_addr] <= mem_wdata;
        written[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= written[mem_addr] ? mem_arr[mem_addr] : init_pat(mem_addr);
      end
    end
  end

  typedef struct {
    logic          we;
    logic          lock;
    logic [AS-1:0] addr;
    logic [WS-1:0] wdata;
  } req_t;

  typedef struct {
    int            due;
    logic          we;
    logic [AS-1:0] addr;
    logic [WS-1:0] wdata;
  } mcmd_t;

  typedef struct {
    int            due;
    int            owner;
    logic [WS-1:0] data;
  } rdexp_t;

  req_t   q0[$], q1[$];
  mcmd_t  mem_q[$];
  rdexp_t rd_q[$];
  int     le_q[$];

  logic [WS-1:0] shadow [256];
  int            m_state;  // 0 idle, 1 owned by req0, 2 owned by req1
  int            m_last;
  int            m_cnt;
  logic [AS-1:0] exp_maddr;
  logic [WS-1:0] exp_mwdata;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int first_r1;
  int le_seen;
  int base;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic req_t mk(input logic we, input logic lock, input logic [AS-1:0] addr,
                              input logic [WS-1:0] wdata);
    req_t r;
    r.we = we;
    r.lock = lock;
    r.addr = addr;
    r.wdata = wdata;
    return r;
  endfunction

  // One clock cycle: drive, check at the falling edge, advance the model, step past the edge.
  task automatic step();
    int     g;
    req_t   it;
    mcmd_t  mc;
    rdexp_t rc;
    bit     v0, v1;
    v0 = (q0.size() != 0);
    v1 = (q1.size() != 0);
    req0_valid = v0;
    req1_valid = v1;
    if (v0) begin
      req0_we = q0[0].we; req0_lock = q0[0].lock;
      req0_addr = q0[0].addr; req0_wdata = q0[0].wdata;
    end
    if (v1) begin
      req1_we = q1[0].we; req1_lock = q1[0].lock;
      req1_addr = q1[0].addr; req1_wdata = q1[0].wdata;
    end
    @(negedge clk);
    g = -1;
    if (rst) begin
      case (m_state)
        0: begin
          if (v0 && v1) g = (m_last == 1) ? 0 : 1;
          else if (v0) g = 0;
          else if (v1) g = 1;
        end
        1: if (v0) g = 0;
        2: if (v1) g = 1;
        default: g = -1;
      endcase
    end
    check_eq("ready0", 32'(req0_ready), 32'(g == 0));
    check_eq("ready1", 32'(req1_ready), 32'(g == 1));
    if (req1_ready && first_r1 < 0) first_r1 = cyc;
    if (lock_err) le_seen++;

    if (mem_q.size() != 0 && mem_q[0].due == cyc) begin
      mc = mem_q.pop_front();
      check_eq("mem_en", 32'(mem_en), 32'd1);
      check_eq("mem_wr_en", 32'(mem_wr_en), 32'(mc.we));
      exp_maddr = mc.addr;
      exp_mwdata = mc.wdata;
    end else begin
      check_eq("mem_en_idle", 32'(mem_en), 32'd0);
      check_eq("mem_wr_en_idle", 32'(mem_wr_en), 32'd0);
    end
    check_eq("mem_addr", 32'(mem_addr), 32'(exp_maddr));
    check_eq("mem_wdata", 32'(mem_wdata), 32'(exp_mwdata));

    if (rd_q.size() != 0 && rd_q[0].due == cyc) begin
      rc = rd_q.pop_front();
      check_eq("rvalid0", 32'(req0_rvalid), 32'(rc.owner == 0));
      check_eq("rvalid1", 32'(req1_rvalid), 32'(rc.owner == 1));
      check_eq("rdata", 32'(rdata), 32'(rc.data));
    end else begin
      check_eq("rvalid0_idle", 32'(req0_rvalid), 32'd0);
      check_eq("rvalid1_idle", 32'(req1_rvalid), 32'd0);
    end

    if (le_q.size() != 0 && le_q[0] == cyc) begin
      void'(le_q.pop_front());
      check_eq("lock_err", 32'(lock_err), 32'd1);
    end else begin
      check_eq("lock_err_idle", 32'(lock_err), 32'd0);
    end

    if (g >= 0) begin
      it = (g == 1) ? q1.pop_front() : q0.pop_front();
      mc.due = cyc + 1; mc.we = it.we; mc.addr = it.addr; mc.wdata = it.wdata;
      mem_q.push_back(mc);
      if (it.we) begin
        shadow[it.addr] = it.wdata;
      end else begin
        rc.due = cyc + 2; rc.owner = g; rc.data = shadow[it.addr];
        rd_q.push_back(rc);
      end
      m_last = g;
      if (it.lock) begin
        m_cnt++;
        if (m_cnt == LM) begin
          m_state = 0;
          m_cnt = 0;
          le_q.push_back(cyc + 1);
        end else begin
          m_state = g + 1;
        end
      end else begin
        m_state = 0;
        m_cnt = 0;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic apply_reset();
    q0.delete();
    q1.delete();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b0;
    #1;
    check_eq("rst_mem_en", 32'(mem_en), 32'd0);
    check_eq("rst_mem_wr_en", 32'(mem_wr_en), 32'd0);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check_eq("rst_rvalid0", 32'(req0_rvalid), 32'd0);
    check_eq("rst_rvalid1", 32'(req1_rvalid), 32'd0);
    check_eq("rst_lock_err", 32'(lock_err), 32'd0);
    mem_q.delete();
    rd_q.delete();
    le_q.delete();
    m_state = 0;
    m_last = 1;
    m_cnt = 0;
    exp_maddr = '0;
    exp_mwdata = '0;
    step();
    step();
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() + q1.size() + mem_q.size() + rd_q.size() + le_q.size() != 0 ||
            m_state != 0) && n < 300) begin
      if (m_state == 1 && q0.size() == 0) q0.push_back(mk(1'b0, 1'b0, 8'h01, 16'h0));
      if (m_state == 2 && q1.size() == 0) q1.push_back(mk(1'b0, 1'b0, 8'h02, 16'h0));
      step();
      n++;
    end
    check_eq("drain_done", q0.size() + q1.size() + mem_q.size() + rd_q.size() + le_q.size(),
             32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) shadow[i] = init_pat(8'(i));
    first_r1 = -1;
    le_seen = 0;
    #2;
    apply_reset();

    // Tie from reset: req0 first, then req1; first transfer on the first released edge.
    q0.push_back(mk(1'b0, 1'b0, 8'h10, 16'h1111));
    q1.push_back(mk(1'b0, 1'b0, 8'h20, 16'h2222));
    rst = 1'b1;
    base = cyc;
    first_r1 = -1;
    repeat (6) step();
    check_eq("tie_ready1_cycle", 32'(first_r1 - base), 32'd1);

    // Write then read back through the other requester.
    q0.push_back(mk(1'b1, 1'b0, 8'h04, 16'hBEEF));
    repeat (4) step();
    q1.push_back(mk(1'b0, 1'b0, 8'h04, 16'h0));
    repeat (5) step();

    // Short lock: req1 waits out three req0 transfers.
    q0.push_back(mk(1'b0, 1'b1, 8'h11, 16'h0));
    q0.push_back(mk(1'b1, 1'b1, 8'h12, 16'h1212));
    q0.push_back(mk(1'b0, 1'b0, 8'h12, 16'h0));
    q1.push_back(mk(1'b0, 1'b0, 8'h21, 16'h0));
    base = cyc;
    first_r1 = -1;
    repeat (8) step();
    check_eq("lock3_ready1_cycle", 32'(first_r1 - base), 32'd3);

    // Lock held past the limit: forced release after the LM-th transfer.
    for (int i = 0; i < LM + 4; i++) q0.push_back(mk(1'b1, 1'b1, 8'(8'h40 + i), 16'(i * 3)));
    q0.push_back(mk(1'b0, 1'b0, 8'h45, 16'h0));
    q1.push_back(mk(1'b0, 1'b0, 8'h41, 16'h0));
    base = cyc;
    first_r1 = -1;
    le_seen = 0;
    repeat (LM + 14) step();
    check_eq("lockmax_ready1_cycle", 32'(first_r1 - base), 32'(LM));
    check_eq("lockmax_err_pulses", 32'(le_seen), 32'd1);
    drain();

    // Random mix of reads, writes and short locks.
    for (int i = 0; i < 120; i++) begin
      if (q0.size() < 3 && $urandom_range(0, 9) < 4)
        q0.push_back(mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                        8'($urandom_range(0, 255)), 16'($urandom)));
      if (q1.size() < 3 && $urandom_range(0, 9) < 4)
        q1.push_back(mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                        8'($urandom_range(0, 255)), 16'($urandom)));
      step();
    end
    drain();

    // Reset while a read is in flight: the read must never return.
    q0.push_back(mk(1'b0, 1'b0, 8'h30, 16'h0));
    step();
    apply_reset();
    rst = 1'b1;
    repeat (5) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
